// File: rtl/hevc_idct4_1d_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | hevc_xform_pkg : shared constants, lane/row types and rounding helper    |
// | Rev 1.0 - initial release                                                |
// +--------------------------------------------------------------------------+
package hevc_xform_pkg;

  localparam int C64    = 64;
  localparam int C83    = 83;
  localparam int C36    = 36;
  localparam int COEF_W = 16;
  localparam int SAMP_W = 16;

  typedef logic signed [COEF_W-1:0] coef_t;
  typedef logic signed [SAMP_W-1:0] samp_t;

  typedef struct packed {
    coef_t x3;
    coef_t x2;
    coef_t x1;
    coef_t x0;
  } coef_row_t;

  typedef struct packed {
    samp_t y3;
    samp_t y2;
    samp_t y1;
    samp_t y0;
  } samp_row_t;

  // Round half up, then arithmetic (floor) shift.
  function automatic logic signed [63:0] round_shift(input logic signed [63:0] val,
                                                     input int sh);
    return (val + (64'sd1 <<< (sh - 1))) >>> sh;
  endfunction

endpackage
`default_nettype wire

// File: rtl/hevc_idct4_1d_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | hevc_idct4_1d_if : coefficient-in / sample-out valid-ready bundle        |
// | Rev 1.0 - initial release                                                |
// +--------------------------------------------------------------------------+
interface hevc_idct4_1d_if
  import hevc_xform_pkg::*;
#(
  parameter int IN_W  = COEF_W,
  parameter int OUT_W = SAMP_W
);
  logic               in_valid;
  logic               in_ready;
  logic [4*IN_W-1:0]  in_coef;
  logic               out_valid;
  logic               out_ready;
  logic [4*OUT_W-1:0] out_samp;
  logic [1:0]         out_row;
  logic               out_last;

  modport master (
    output in_valid, in_coef, out_ready,
    input  in_ready, out_valid, out_samp, out_row, out_last
  );

  modport slave (
    input  in_valid, in_coef, out_ready,
    output in_ready, out_valid, out_samp, out_row, out_last
  );
endinterface
`default_nettype wire

// File: rtl/hevc_idct4_1d_butterfly.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | hevc_idct4_butterfly : combinational even/odd partial sums of 4-pt IDCT  |
// | Rev 1.0 - initial release                                                |
// +--------------------------------------------------------------------------+
module hevc_idct4_butterfly
  import hevc_xform_pkg::*;
#(
  parameter int IN_W  = 16,
  parameter int ACC_W = IN_W + 9
) (
  input  wire signed [IN_W-1:0]  x0,
  input  wire signed [IN_W-1:0]  x1,
  input  wire signed [IN_W-1:0]  x2,
  input  wire signed [IN_W-1:0]  x3,
  output logic signed [ACC_W-1:0] e0,
  output logic signed [ACC_W-1:0] e1,
  output logic signed [ACC_W-1:0] o0,
  output logic signed [ACC_W-1:0] o1
);
  localparam logic signed [ACC_W-1:0] c_k64 = ACC_W'(C64);
  localparam logic signed [ACC_W-1:0] c_k83 = ACC_W'(C83);
  localparam logic signed [ACC_W-1:0] c_k36 = ACC_W'(C36);

  logic signed [ACC_W-1:0] w_x0, w_x1, w_x2, w_x3;

  // Widen before any arithmetic so no intermediate can overflow.
  assign w_x0 = {{(ACC_W-IN_W){x0[IN_W-1]}}, x0};
  assign w_x1 = {{(ACC_W-IN_W){x1[IN_W-1]}}, x1};
  assign w_x2 = {{(ACC_W-IN_W){x2[IN_W-1]}}, x2};
  assign w_x3 = {{(ACC_W-IN_W){x3[IN_W-1]}}, x3};

  assign e0 = c_k64 * (w_x0 + w_x2);
  assign e1 = c_k64 * (w_x0 - w_x2);
  assign o0 = c_k83 * w_x1 + c_k36 * w_x3;
  assign o1 = c_k36 * w_x1 - c_k83 * w_x3;

endmodule
`default_nettype wire

// File: rtl/hevc_idct4_1d.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | hevc_idct4_1d : 2-stage pipelined 4-point HEVC inverse DCT, 1 row/cycle  |
// | HEVC_IDCT4_SAT_EN : saturate outputs to OUT_W instead of wrapping        |
// | Rev 1.0 - initial release                                                |
// +--------------------------------------------------------------------------+
module hevc_idct4_1d
  import hevc_xform_pkg::*;
#(
  parameter int IN_W  = 16,
  parameter int OUT_W = 16,
  parameter int SHIFT = 7
) (
  input  wire             clk,
  input  wire             rst_n,
  hevc_idct4_1d_if.slave  bus
);
  localparam int ACC_W = IN_W + 9;

  logic [1:0]              r_rst_sync;
  logic                    w_rst_n;
  logic                    w_out_adv;
  logic                    r_s1_v;
  logic [1:0]              r_s1_row;
  logic [1:0]              r_cnt;
  logic signed [ACC_W-1:0] r_e0, r_e1, r_o0, r_o1;
  logic signed [ACC_W-1:0] w_e0, w_e1, w_o0, w_o1;
  logic signed [ACC_W-1:0] w_y [4];
  logic [4*OUT_W-1:0]      w_samp_nxt;
  logic                    r_out_v;
  logic [4*OUT_W-1:0]      r_out_samp;
  logic [1:0]              r_out_row;
  logic                    r_out_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_rst_sync <= 2'b00;
    else        r_rst_sync <= {r_rst_sync[0], 1'b1};
  end
  assign w_rst_n = r_rst_sync[1];

  // Input is refused until the synchronised reset has released the pipeline.
  assign w_out_adv    = !r_out_v || bus.out_ready;
  assign bus.in_ready = w_rst_n && (!r_s1_v || w_out_adv);

  hevc_idct4_butterfly #(.IN_W(IN_W), .ACC_W(ACC_W)) u_bfly (
    .x0 (bus.in_coef[0*IN_W +: IN_W]),
    .x1 (bus.in_coef[1*IN_W +: IN_W]),
    .x2 (bus.in_coef[2*IN_W +: IN_W]),
    .x3 (bus.in_coef[3*IN_W +: IN_W]),
    .e0 (w_e0),
    .e1 (w_e1),
    .o0 (w_o0),
    .o1 (w_o1)
  );

  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_s1_v   <= 1'b0;
      r_s1_row <= 2'd0;
      r_cnt    <= 2'd0;
      r_e0     <= '0;
      r_e1     <= '0;
      r_o0     <= '0;
      r_o1     <= '0;
    end else if (bus.in_ready) begin
      r_s1_v <= bus.in_valid;
      if (bus.in_valid) begin
        r_e0     <= w_e0;
        r_e1     <= w_e1;
        r_o0     <= w_o0;
        r_o1     <= w_o1;
        r_s1_row <= r_cnt;
        r_cnt    <= r_cnt + 2'd1;
      end
    end
  end

  assign w_y[0] = r_e0 + r_o0;
  assign w_y[1] = r_e1 + r_o1;
  assign w_y[2] = r_e1 - r_o1;
  assign w_y[3] = r_e0 - r_o0;

  for (genvar i = 0; i < 4; i++) begin : g_lane
    logic signed [63:0] w_r;
    logic [OUT_W-1:0]   w_lane;

    assign w_r = round_shift(64'(w_y[i]), SHIFT);
`ifdef HEVC_IDCT4_SAT_EN
    localparam logic signed [63:0] c_max = (64'sd1 <<< (OUT_W - 1)) - 64'sd1;
    localparam logic signed [63:0] c_min = -(64'sd1 <<< (OUT_W - 1));

    always_comb begin
      w_lane = w_r[OUT_W-1:0];
      if (w_r > c_max)      w_lane = c_max[OUT_W-1:0];
      else if (w_r < c_min) w_lane = c_min[OUT_W-1:0];
    end
`else
    logic [63-OUT_W:0] w_unused_hi;

    assign w_unused_hi = w_r[63:OUT_W];
    assign w_lane      = w_r[OUT_W-1:0];
`endif
    assign w_samp_nxt[i*OUT_W +: OUT_W] = w_lane;
  end

  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_out_v    <= 1'b0;
      r_out_samp <= '0;
      r_out_row  <= 2'd0;
      r_out_last <= 1'b0;
    end else if (w_out_adv) begin
      r_out_v <= r_s1_v;
      if (r_s1_v) begin
        r_out_samp <= w_samp_nxt;
        r_out_row  <= r_s1_row;
        r_out_last <= (r_s1_row == 2'd3);
      end
    end
  end

  assign bus.out_valid = r_out_v;
  assign bus.out_samp  = r_out_samp;
  assign bus.out_row   = r_out_row;
  assign bus.out_last  = r_out_last;

endmodule
`default_nettype wire

// File: tb/tb_hevc_idct4_1d.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_hevc_idct4_1d : self-checking bench, matrix-form IDCT reference model |
// | Rev 1.0 - initial release                                                |
// +--------------------------------------------------------------------------+
module tb_hevc_idct4_1d;
  import hevc_xform_pkg::*;

  localparam int IN_W  = 16;
  localparam int OUT_W = 16;
  localparam int SHIFT = 7;
  localparam int NRAND = 1000;

  // Row k of the inverse transform matrix weights coefficient Xk.
  localparam int T [4][4] = '{'{64, 64, 64, 64}, '{83, 36, -36, -83},
                              '{64, -64, -64, 64}, '{36, -83, 83, -36}};

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;

  typedef struct {
    logic [63:0] samp;
    logic [1:0]  row;
  } exp_t;

  exp_t exp_q[$];
  int   mrow = 0;

  always #5 clk = ~clk;

  hevc_idct4_1d_if #(.IN_W(IN_W), .OUT_W(OUT_W)) bus ();

  hevc_idct4_1d #(.IN_W(IN_W), .OUT_W(OUT_W), .SHIFT(SHIFT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  function automatic int ref_sample(input longint acc);
    longint n, q, div, half;
    div  = longint'(1) << SHIFT;
    half = longint'(1) << (OUT_W - 1);
    n = acc + (div / 2);
    q = n / div;
    if (n < 0 && (n % div) != 0) q = q - 1;
`ifdef HEVC_IDCT4_SAT_EN
    if (q > half - 1) q = half - 1;
    else if (q < -half) q = -half;
`else
    q = q & (2 * half - 1);
    if (q >= half) q = q - 2 * half;
`endif
    return int'(q);
  endfunction

  function automatic logic [63:0] ref_row(input logic [63:0] c);
    logic [63:0]       r;
    logic signed [15:0] x;
    longint            acc;
    r = '0;
    for (int n = 0; n < 4; n++) begin
      acc = 0;
      for (int k = 0; k < 4; k++) begin
        x   = c[k*16 +: 16];
        acc = acc + longint'(T[k][n]) * longint'(x);
      end
      r[n*16 +: 16] = 16'(ref_sample(acc));
    end
    return r;
  endfunction

  function automatic logic [63:0] rand_coef();
    logic [63:0] c;
    for (int i = 0; i < 4; i++) begin
      case ($urandom_range(0, 7))
        0:       c[i*16 +: 16] = 16'h7FFF;
        1:       c[i*16 +: 16] = 16'h8000;
        default: c[i*16 +: 16] = 16'($urandom);
      endcase
    end
    return c;
  endfunction

  task automatic push_expected(input logic [63:0] c);
    exp_t e;
    e.samp = ref_row(c);
    e.row  = 2'(mrow);
    exp_q.push_back(e);
    mrow = (mrow + 1) % 4;
  endtask

  task automatic do_reset();
    bus.in_valid  = 1'b0;
    bus.in_coef   = '0;
    bus.out_ready = 1'b1;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    exp_q.delete();
    mrow = 0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    #1;
    n_tests++;
    if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
    n_tests++;
    if (bus.out_samp !== 64'd0) begin n_fail++; $display("FAIL reset_out_samp: got %h want 0", bus.out_samp); end
    n_tests++;
    if (bus.out_row !== 2'd0) begin n_fail++; $display("FAIL reset_out_row: got %0d want 0", bus.out_row); end
    n_tests++;
    if (bus.out_last !== 1'b0) begin n_fail++; $display("FAIL reset_out_last: got %b want 0", bus.out_last); end
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    n_tests++;
    if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready); end
  endtask

  task automatic test_known_vectors();
    coef_row_t   cr [3];
    logic [15:0] y0_want [3];
    logic [63:0] want;
    cr[0] = '{x3: 16'sd0, x2: 16'sd0, x1: 16'sd0, x0: 16'sd64};
    cr[1] = '{x3: 16'sd0, x2: 16'sd0, x1: 16'sd64, x0: 16'sd0};
    cr[2] = '{x3: 16'sd32767, x2: 16'sd0, x1: 16'sd32767, x0: 16'sd32767};
    y0_want[0] = 16'd32;
    y0_want[1] = 16'd42;
`ifdef HEVC_IDCT4_SAT_EN
    y0_want[2] = 16'h7FFF;
`else
    y0_want[2] = 16'hB6FF;
`endif
    for (int v = 0; v < 3; v++) begin
      @(negedge clk);
      bus.in_valid  = 1'b1;
      bus.in_coef   = cr[v];
      bus.out_ready = 1'b1;
      want = ref_row(cr[v]);
      #1;
      n_tests++;
      if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL kv%0d_in_ready: got %b want 1", v, bus.in_ready); end
      @(negedge clk);
      bus.in_valid = 1'b0;
      #1;
      n_tests++;
      if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL kv%0d_early_valid: got %b want 0", v, bus.out_valid); end
      @(negedge clk);
      #1;
      n_tests++;
      if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL kv%0d_latency_valid: got %b want 1", v, bus.out_valid); end
      n_tests++;
      if (bus.out_samp !== want) begin n_fail++; $display("FAIL kv%0d_samp: got %h want %h", v, bus.out_samp, want); end
      n_tests++;
      if (bus.out_samp[15:0] !== y0_want[v]) begin n_fail++; $display("FAIL kv%0d_y0: got %h want %h", v, bus.out_samp[15:0], y0_want[v]); end
      n_tests++;
      if (bus.out_row !== 2'(v)) begin n_fail++; $display("FAIL kv%0d_row: got %0d want %0d", v, bus.out_row, v); end
      @(negedge clk);
      #1;
      n_tests++;
      if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL kv%0d_drain: got %b want 0", v, bus.out_valid); end
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] c;
    exp_t        e;
    do_reset();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (i < 8) begin
        c = rand_coef();
        bus.in_valid = 1'b1;
        bus.in_coef  = c;
        push_expected(c);
      end else begin
        bus.in_valid = 1'b0;
      end
      #1;
      if (i < 8) begin
        n_tests++;
        if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_in_ready%0d: got %b want 1", i, bus.in_ready); end
      end
      if (i >= 2) begin
        n_tests++;
        if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_valid%0d: got %b want 1", i, bus.out_valid); end
        n_tests++;
        if (bus.out_row !== 2'((i - 2) % 4)) begin n_fail++; $display("FAIL b2b_row%0d: got %0d want %0d", i, bus.out_row, (i - 2) % 4); end
        n_tests++;
        if (bus.out_last !== ((i - 2) % 4 == 3)) begin n_fail++; $display("FAIL b2b_last%0d: got %b want %b", i, bus.out_last, ((i - 2) % 4 == 3)); end
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          n_tests++;
          if (bus.out_samp !== e.samp) begin n_fail++; $display("FAIL b2b_samp%0d: got %h want %h", i, bus.out_samp, e.samp); end
        end
      end
    end
    @(negedge clk);
    #1;
    n_tests++;
    if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_tail_valid: got %b want 0", bus.out_valid); end
  endtask

  task automatic test_random();
    int          sent = 0;
    int          got = 0;
    int          cyc = 0;
    bit          pending = 1'b0;
    bit          prev_stall = 1'b0;
    bit          ordy;
    logic [63:0] pc = '0;
    logic [63:0] ps = '0;
    logic [1:0]  pr = '0;
    exp_t        e;
    while (got < NRAND && cyc < 20000) begin
      @(negedge clk);
      cyc++;
      if (prev_stall) begin
        n_tests++;
        if (bus.out_valid !== 1'b1 || bus.out_samp !== ps || bus.out_row !== pr) begin
          n_fail++;
          $display("FAIL rnd_stall_hold: got v=%b %h r%0d want v=1 %h r%0d", bus.out_valid, bus.out_samp, bus.out_row, ps, pr);
        end
      end
      ordy = 1'($urandom_range(0, 1));
      if (!pending && sent < NRAND && $urandom_range(0, 9) < 7) begin
        pc      = rand_coef();
        pending = 1'b1;
      end
      bus.in_valid  = pending;
      bus.in_coef   = pc;
      bus.out_ready = ordy;
      #1;
      if (bus.out_valid && ordy) begin
        got++;
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL rnd_extra_row: got %h with no row outstanding", bus.out_samp);
        end else begin
          e = exp_q.pop_front();
          n_tests++;
          if (bus.out_samp !== e.samp) begin n_fail++; $display("FAIL rnd_samp: got %h want %h", bus.out_samp, e.samp); end
          n_tests++;
          if (bus.out_row !== e.row || bus.out_last !== (e.row == 2'd3)) begin
            n_fail++;
            $display("FAIL rnd_row: got %0d/%b want %0d/%b", bus.out_row, bus.out_last, e.row, (e.row == 2'd3));
          end
        end
      end
      if (pending && bus.in_ready) begin
        push_expected(pc);
        pending = 1'b0;
        sent++;
      end
      prev_stall = bus.out_valid && !ordy;
      ps = bus.out_samp;
      pr = bus.out_row;
    end
    n_tests++;
    if (got < NRAND) begin n_fail++; $display("FAIL rnd_timeout: got %0d rows want %0d", got, NRAND); end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    n_tests++;
    if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL rnd_tail_valid: got %b want 0", bus.out_valid); end
  endtask

  task automatic test_reset_midflight();
    logic [63:0] c;
    logic [63:0] want;
    @(negedge clk);
    bus.in_valid  = 1'b1;
    bus.in_coef   = rand_coef();
    bus.out_ready = 1'b0;
    @(negedge clk);
    bus.in_coef = rand_coef();
    @(negedge clk);
    bus.in_valid = 1'b0;
    #1;
    n_tests++;
    if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL mid_fill_valid: got %b want 1", bus.out_valid); end
    #2;
    rst_n = 1'b0;
    #1;
    n_tests++;
    if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_async_valid: got %b want 0", bus.out_valid); end
    n_tests++;
    if (bus.out_samp !== 64'd0 || bus.out_row !== 2'd0) begin
      n_fail++;
      $display("FAIL mid_async_data: got %h r%0d want 0 r0", bus.out_samp, bus.out_row);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    exp_q.delete();
    mrow = 0;
    repeat (3) @(negedge clk);
    #1;
    n_tests++;
    if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_post_valid: got %b want 0", bus.out_valid); end
    @(negedge clk);
    c = rand_coef();
    want = ref_row(c);
    bus.in_valid = 1'b1;
    bus.in_coef  = c;
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(negedge clk);
    #1;
    n_tests++;
    if (bus.out_valid !== 1'b1 || bus.out_row !== 2'd0) begin
      n_fail++;
      $display("FAIL mid_first_row: got v=%b r%0d want v=1 r0", bus.out_valid, bus.out_row);
    end
    n_tests++;
    if (bus.out_samp !== want) begin n_fail++; $display("FAIL mid_first_samp: got %h want %h", bus.out_samp, want); end
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_coef   = '0;
    bus.out_ready = 1'b0;
    test_reset();
    test_known_vectors();
    test_back_to_back();
    test_random();
    test_reset_midflight();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
